// File: rtl/core_pipe_stage_hzd_if.sv
// Handshake and operand bundle for core_pipe_stage_hzd. The slave modport is
// the stage's view; the master modport is the view of the surrounding pipeline.
interface core_pipe_stage_hzd_if #(
  parameter int unsigned DW      = 64,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned RFIDX_W = 5
);
  logic                    valid_in;
  logic                    ready_in;
  logic [DW-1:0]           i_payload;
  logic                    i_rs1_ren;
  logic                    i_rs2_ren;
  logic [RFIDX_W-1:0]      i_rs1_idx;
  logic [RFIDX_W-1:0]      i_rs2_idx;
  logic [NSRC-1:0]         prd_wen;
  logic [NSRC*RFIDX_W-1:0] prd_idx;
  logic                    i_flush;
  logic                    valid_out;
  logic                    ready_out;
  logic [DW-1:0]           o_payload;
  logic                    o_rs1_ren;
  logic                    o_rs2_ren;
  logic [RFIDX_W-1:0]      o_rs1_idx;
  logic [RFIDX_W-1:0]      o_rs2_idx;
  logic                    o_hzd_stall;

  modport slave (
    input  valid_in, i_payload, i_rs1_ren, i_rs2_ren, i_rs1_idx, i_rs2_idx,
    input  prd_wen, prd_idx, i_flush, ready_out,
    output ready_in, valid_out, o_payload, o_rs1_ren, o_rs2_ren,
    output o_rs1_idx, o_rs2_idx, o_hzd_stall
  );

  modport master (
    output valid_in, i_payload, i_rs1_ren, i_rs2_ren, i_rs1_idx, i_rs2_idx,
    output prd_wen, prd_idx, i_flush, ready_out,
    input  ready_in, valid_out, o_payload, o_rs1_ren, o_rs2_ren,
    input  o_rs1_idx, o_rs2_idx, o_hzd_stall
  );
endinterface

// File: rtl/core_pipe_stage_hzd.sv
// Pipeline stage with RAW-hazard bubble insertion. Define CORE_PIPE_SKID_EN for
// a two-entry main+skid buffer with registered ready_in; default is one entry.
module core_pipe_stage_hzd #(
  parameter int unsigned DW      = 64,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned RFIDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  core_pipe_stage_hzd_if.slave bus
);

  typedef struct packed {
    logic [DW-1:0]      payload;
    logic               rs1_ren;
    logic [RFIDX_W-1:0] rs1_idx;
    logic               rs2_ren;
    logic [RFIDX_W-1:0] rs2_idx;
  } entry_t;

  // Bit 0 = main valid, bit 1 = skid valid, so both are raw flop outputs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_FULL  = 2'b11
  } occ_e;

  occ_e            state_q, state_d;
  entry_t          main_q;
  entry_t          in_ent;
  logic            main_valid;
  logic            skid_valid;
  logic            hzd;
  logic            fire_in;
  logic            fire_out;
  logic            load_main_in;
  logic [NSRC-1:0] prd_hit;

`ifdef CORE_PIPE_SKID_EN
  entry_t skid_q;
  logic   load_main_skid;
  logic   load_skid;
`endif

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  always_comb begin
    in_ent         = '0;
    in_ent.payload = bus.i_payload;
    in_ent.rs1_ren = bus.i_rs1_ren;
    in_ent.rs1_idx = bus.i_rs1_idx;
    in_ent.rs2_ren = bus.i_rs2_ren;
    in_ent.rs2_idx = bus.i_rs2_idx;
  end

  // Producer index 0 is the hardwired zero register and never creates a hazard.
  for (genvar k = 0; k < NSRC; k++) begin : g_prd
    logic [RFIDX_W-1:0] pidx;
    assign pidx       = bus.prd_idx[k*RFIDX_W +: RFIDX_W];
    assign prd_hit[k] = bus.prd_wen[k] && (pidx != '0) &&
                        ((main_q.rs1_ren && (main_q.rs1_idx == pidx)) ||
                         (main_q.rs2_ren && (main_q.rs2_idx == pidx)));
  end

  assign hzd           = main_valid & (|prd_hit);
  assign bus.valid_out = main_valid & ~hzd & ~bus.i_flush;
  assign fire_out      = bus.valid_out & bus.ready_out;
  assign fire_in       = bus.valid_in & bus.ready_in;

`ifdef CORE_PIPE_SKID_EN
  assign bus.ready_in = ~skid_valid;
`else
  assign bus.ready_in = ~main_valid | fire_out;
`endif

  assign bus.o_hzd_stall = hzd;
  assign bus.o_payload   = main_q.payload;
  assign bus.o_rs1_ren   = main_q.rs1_ren;
  assign bus.o_rs1_idx   = main_q.rs1_idx;
  assign bus.o_rs2_ren   = main_q.rs2_ren;
  assign bus.o_rs2_idx   = main_q.rs2_idx;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
`ifdef CORE_PIPE_SKID_EN
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
`endif
    if (bus.i_flush) begin
      // Flush drops every held entry and swallows a beat accepted this cycle.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_in) begin
            state_d      = ST_MAIN;
            load_main_in = 1'b1;
          end
        end
        ST_MAIN: begin
          if (fire_out && fire_in) begin
            load_main_in = 1'b1;
          end else if (fire_out) begin
            state_d = ST_EMPTY;
`ifdef CORE_PIPE_SKID_EN
          end else if (fire_in) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
`endif
          end
        end
`ifdef CORE_PIPE_SKID_EN
        ST_FULL: begin
          if (fire_out) begin
            state_d        = ST_MAIN;
            load_main_skid = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_ent;
`ifdef CORE_PIPE_SKID_EN
    end else if (load_main_skid) begin
      main_q <= skid_q;
`endif
    end
  end

`ifdef CORE_PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_ent;
    end
  end
`endif

endmodule

// File: doc/core_pipe_stage_hzd.md
CORE_PIPE_STAGE_HZD -- requirements
Module: core_pipe_stage_hzd

Interface
REQ-001 SHALL have parameter DW, default 64, meaning payload width in bits.
REQ-002 SHALL have parameter NSRC, default 2, meaning number of producer (write-back) ports checked for RAW hazards.
REQ-003 SHALL have parameter RFIDX_W, default 5, meaning register-index width.
REQ-004 SHALL have port clk  input  1  clock, with all state updating on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port valid_in  input  1  upstream beat valid.
REQ-007 SHALL have port ready_in  output  1  stage can accept a beat.
REQ-008 SHALL have port i_payload  input  DW  opaque upstream data (pc, inst, predict bit, ...).
REQ-009 SHALL have ports i_rs1_ren/i_rs2_ren  input  1 each  source-read enables of the beat.
REQ-010 SHALL have ports i_rs1_idx/i_rs2_idx  input  RFIDX_W each  source indices of the beat.
REQ-011 SHALL have port prd_wen  input  NSRC  per-producer write enable.
REQ-012 SHALL have port prd_idx  input  NSRC*RFIDX_W  per-producer rd index, with producer k at bits [k*RFIDX_W +: RFIDX_W].
REQ-013 SHALL have port i_flush  input  1  pipeline flush request.
REQ-014 SHALL have port valid_out  output  1  downstream beat valid.
REQ-015 SHALL have port ready_out  input  1  downstream accepts.
REQ-016 SHALL have ports o_payload (output, DW), o_rs1_ren/o_rs2_ren (output, 1 each) and o_rs1_idx/o_rs2_idx (output, RFIDX_W each), carrying the head-entry fields.
REQ-017 SHALL have port o_hzd_stall  output  1  head entry blocked by RAW hazard this cycle.

Function
REQ-018 The head entry (main) SHALL drive all o_* fields directly from registers.
REQ-019 hzd SHALL be 1 when main is valid and, for some producer k, prd_wen[k]=1, prd_idx[k]!=0, and either (o_rs1_ren & o_rs1_idx==prd_idx[k]) or (o_rs2_ren & o_rs2_idx==prd_idx[k]) holds.
REQ-020 o_hzd_stall SHALL equal hzd, and valid_out SHALL equal main_valid & ~hzd & ~i_flush (combinational).
REQ-021 fire_in SHALL equal valid_in & ready_in, and fire_out SHALL equal valid_out & ready_out.
REQ-022 Latency SHALL be 1 cycle: a beat accepted at edge N into an empty stage SHALL present valid_out after edge N unless a hazard is present.
REQ-023 While hzd=1, main SHALL hold its contents unchanged and valid_out SHALL stay 0 (bubble); no beat is lost or duplicated.
REQ-024 Payload and index registers SHALL load only on an accepted beat or an internal skid-to-main move, and SHALL otherwise hold.
REQ-025 When i_flush=1 at an edge, all entry valids SHALL clear, and any beat accepted in that same cycle SHALL be discarded; ready_in is not gated by i_flush.
REQ-026 If fire_out and fire_in occur in the same cycle, the incoming beat SHALL become the new main with no bubble.
REQ-027 Beats SHALL leave in the order they were accepted.

Reset
REQ-028 While rst_n=0, all valids SHALL be 0, o_payload SHALL be 0, o_rs*_ren SHALL be 0, o_rs*_idx SHALL be 0, valid_out SHALL be 0 and o_hzd_stall SHALL be 0.
REQ-029 Assertion of rst_n mid-transfer SHALL drop all held beats immediately; ready_in SHALL be 1 on the first cycle after release.

Configuration
REQ-030 Macro CORE_PIPE_SKID_EN SHALL select the buffering scheme.
REQ-031 With CORE_PIPE_SKID_EN defined, the stage SHALL hold two entries (main and skid), with ready_in = ~skid_valid taken straight from a register (no combinational ready_out/hzd -> ready_in path).
  - A beat accepted while main is valid and not firing goes to skid.
  - When main fires, skid moves to main in the same edge.
  - Capacity is 2.
REQ-032 Without CORE_PIPE_SKID_EN, the stage SHALL hold one entry, with ready_in = ~main_valid | fire_out (combinational) and capacity 1.

Verification
REQ-033 Scenario: reset, then valid_in=1 with payload 0x1234 and ready_out=1 -> valid_out=1 one cycle later with o_payload=0x1234, then back-to-back beats stream at 1 per cycle.
REQ-034 Scenario: main has rs1_ren=1, rs1_idx=5, and prd_wen[1]=1, prd_idx[1]=5 for 3 cycles -> valid_out=0 and o_hzd_stall=1 for 3 cycles, then the beat issues with payload unchanged; repeating with prd_idx=0 gives no stall.
REQ-035 Scenario: ready_out=0 while 3 beats A,B,C are offered -> with CORE_PIPE_SKID_EN, A and B are accepted, ready_in=0 and C waits; without the macro only A is accepted; after ready_out=1, output order is A,B,C.
REQ-036 Scenario: two entries held and i_flush=1 with valid_in=1 in the same cycle -> valid_out=0 that cycle, the stage is empty next cycle, and the flushed-cycle input is not emitted.
REQ-037 Scenario: rst_n pulsed low mid-stall with 2 entries held -> all outputs return to 0 asynchronously, and ready_in=1 after release.
